// File: rtl/gtech_fd_pipe_if.sv
// Handshake bundle for gtech_fd_pipe: upstream D/DV/DR, downstream Q/QV/QR, FLUSH and CNT.
// QN is present only when GTECH_FD_PIPE_QN_EN is defined.
interface gtech_fd_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
);
  localparam int CNT_W = $clog2(STAGES + 1);

  logic             FLUSH;
  logic [WIDTH-1:0] D;
  logic             DV;
  logic             DR;
  logic [WIDTH-1:0] Q;
  logic             QV;
  logic             QR;
  logic [CNT_W-1:0] CNT;
`ifdef GTECH_FD_PIPE_QN_EN
  logic [WIDTH-1:0] QN;
`endif

  // Valid/ready: a word moves across a boundary on a rising edge where valid and ready
  // are both high; once valid is raised the sender holds data and valid until it moves.
  modport slave (
    input  FLUSH, D, DV, QR,
    output DR, Q, QV, CNT
`ifdef GTECH_FD_PIPE_QN_EN
    , output QN
`endif
  );

  modport master (
    output FLUSH, D, DV, QR,
    input  DR, Q, QV, CNT
`ifdef GTECH_FD_PIPE_QN_EN
    , input QN
`endif
  );
endinterface

// File: rtl/gtech_fd_pipe.sv
// Stallable WIDTH x STAGES register pipe with per-slot valid bits and bubble collapse.
// Optional inverted output QN is enabled by defining GTECH_FD_PIPE_QN_EN.
module gtech_fd_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic              CP,
  input logic              CD,
  gtech_fd_pipe_if.slave   bus
);
  localparam int CNT_W = $clog2(STAGES + 1);

  logic [WIDTH-1:0] data_q [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              in_xfer;
  logic [CNT_W-1:0]  cnt;

  // A slot advances when it is valid and either some slot downstream of it is
  // empty (the bubble collapses) or the output is being taken this cycle.
  always_comb begin
    logic all_full;
    adv      = '0;
    all_full = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i]   = v_q[i] & (~all_full | bus.QR);
      all_full = all_full & v_q[i];
    end
  end

  assign bus.DR  = ~bus.FLUSH & (~v_q[0] | adv[0]);
  assign in_xfer = bus.DV & bus.DR;

  always_comb begin
    load    = '0;
    load[0] = in_xfer;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = adv[i-1];
    end
  end

  always_comb begin
    v_d = '0;
    if (!bus.FLUSH) begin
      for (int i = 0; i < STAGES; i++) begin
        v_d[i] = load[i] | (v_q[i] & ~adv[i]);
      end
    end
  end

  always_ff @(posedge CP) begin
    if (!CD) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      v_q <= v_d;
      // Data moves only with a real transfer; a flush freezes every slot.
      if (!bus.FLUSH) begin
        if (load[0]) data_q[0] <= bus.D;
        for (int i = 1; i < STAGES; i++) begin
          if (load[i]) data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      cnt = cnt + CNT_W'(v_q[i]);
    end
  end

  assign bus.Q   = data_q[STAGES-1];
  assign bus.QV  = v_q[STAGES-1];
  assign bus.CNT = cnt;
`ifdef GTECH_FD_PIPE_QN_EN
  assign bus.QN  = ~data_q[STAGES-1];
`endif
endmodule

// File: tb/tb_gtech_fd_pipe.sv
// Randomized and directed bench for gtech_fd_pipe against an ordered-queue reference model.
module tb_gtech_fd_pipe;
  localparam int         W      = 8;
  localparam int         STAGES = 2;
  localparam logic [7:0] RST_V  = 8'hA5;

  logic cp;
  logic cd;

  gtech_fd_pipe_if #(.WIDTH(W), .STAGES(STAGES)) bus ();

  gtech_fd_pipe #(.WIDTH(W), .STAGES(STAGES), .RESET_VAL(RST_V)) dut (
    .CP  (cp),
    .CD  (cd),
    .bus (bus)
  );

  // Clock / reset
  initial cp = 1'b0;
  always #5 cp = ~cp;

  // Scoreboard: words in flight in acceptance order and the cycle each reaches Q.
  logic [W-1:0] exp_q[$];
  int           arr_q[$];
  logic [W-1:0] exp_last;
  int           cyc;
  int           n_cmp;
  int           n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, req);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic step(input logic cd_v, input logic flush_v, input logic dv_v,
                      input logic [W-1:0] d_v, input logic qr_v);
    logic vis;
    logic dr_exp;
    logic in_x;
    logic out_x;
    int   c;
    cd        = cd_v;
    bus.FLUSH = flush_v;
    bus.DV    = dv_v;
    bus.D     = d_v;
    bus.QR    = qr_v;
    #1;
    // The oldest word is never blocked by anything ahead of it, so it reaches Q
    // exactly STAGES cycles after acceptance.
    vis = (exp_q.size() > 0) && (arr_q[0] <= cyc);
    if (vis) exp_last = exp_q[0];
    dr_exp = !flush_v && !((exp_q.size() == STAGES) && !qr_v);
    chk("QV", 32'(bus.QV), 32'(vis));
    chk("Q", 32'(bus.Q), 32'(exp_last));
    chk("CNT", 32'(bus.CNT), 32'(exp_q.size()));
    chk("DR", 32'(bus.DR), 32'(dr_exp));
`ifdef GTECH_FD_PIPE_QN_EN
    chk("QN", 32'(bus.QN), 32'(~exp_last));
`endif
    in_x  = dv_v && dr_exp;
    out_x = vis && qr_v;
    c     = cyc;
    @(posedge cp);
    cyc++;
    if (!cd_v) begin
      exp_q.delete();
      arr_q.delete();
      exp_last = RST_V;
    end else begin
      if (out_x) begin
        void'(exp_q.pop_front());
        void'(arr_q.pop_front());
      end
      if (flush_v) begin
        exp_q.delete();
        arr_q.delete();
      end else if (in_x) begin
        exp_q.push_back(d_v);
        arr_q.push_back(c + STAGES);
      end
    end
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cyc       = 0;
    exp_last  = RST_V;
    cd        = 1'b0;
    bus.FLUSH = 1'b0;
    bus.DV    = 1'b0;
    bus.D     = '0;
    bus.QR    = 1'b0;
    repeat (2) @(posedge cp);
    #1;

    // Reset state
    step(1, 0, 0, 8'h00, 0);

    // Back-to-back stream with QR high: DR must stay high throughout
    for (int i = 1; i <= 16; i++) begin
      chk("DR_stream", 32'(bus.DR), 32'd1);
      step(1, 0, 1, 8'(i), 1);
    end
    repeat (STAGES + 1) step(1, 0, 0, 8'h00, 1);

    // Fill with QR low, third word waits, then release
    step(1, 0, 1, 8'h01, 0);
    step(1, 0, 1, 8'h02, 0);
    step(1, 0, 1, 8'h03, 0);
    step(1, 0, 1, 8'h03, 0);
    step(1, 0, 1, 8'h03, 1);
    repeat (4) step(1, 0, 0, 8'h00, 1);

    // Single word, QR low: bubble collapses
    step(1, 0, 1, 8'h44, 0);
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 1);

    // Full pipe flushed while DV is high
    step(1, 0, 1, 8'h61, 0);
    step(1, 0, 1, 8'h62, 0);
    step(1, 0, 1, 8'h63, 1'b0);
    step(1, 1, 1, 8'h64, 0);
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 1);

    // Mid-stream reset with DV and QR high
    step(1, 0, 1, 8'h71, 1);
    step(1, 0, 1, 8'h72, 1);
    step(0, 0, 1, 8'h73, 1);
    repeat (4) step(1, 0, 0, 8'h00, 1);

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      logic r_cd;
      logic r_fl;
      r_cd = ($urandom_range(0, 199) != 0);
      r_fl = ($urandom_range(0, 49) == 0);
      step(r_cd, r_fl, 1'($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 2) != 0));
    end
    repeat (STAGES + 2) step(1, 0, 0, 8'h00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
